// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer and its environment: the two reset
// request inputs and the status/reset outputs. Clock and power-on reset stay plain ports.
interface rst_seq_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             ext_rst_n;
  logic             sw_rst_i;
  logic             rst_async_o;
  logic             rst_sync_o;
  logic             rst_done_o;
  logic             busy_o;
  logic [1:0]       cause_o;
  logic [CNT_W-1:0] rst_cnt_o;

  // Environment side: drives requests, observes reset status
  modport master (
    output ext_rst_n,
    output sw_rst_i,
    input  rst_async_o,
    input  rst_sync_o,
    input  rst_done_o,
    input  busy_o,
    input  cause_o,
    input  rst_cnt_o
  );

  // Sequencer side
  modport slave (
    input  ext_rst_n,
    input  sw_rst_i,
    output rst_async_o,
    output rst_sync_o,
    output rst_done_o,
    output busy_o,
    output cause_o,
    output rst_cnt_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges power-on reset, a debounced pushbutton and a software request
// into an active-high reset with async assertion, sync release and a minimum hold time.
module rst_seq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input logic           clk,
  input logic           reset,
  rst_seq_ctrl_if.slave bus
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);

  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
  localparam logic [DebW-1:0]  DebMax   = DebW'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  localparam logic [1:0] StAssert  = 2'd0;
  localparam logic [1:0] StHold    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;
  localparam logic [1:0] StRun     = 2'd3;

  localparam logic [1:0] CausePor = 2'b00;
  localparam logic [1:0] CauseExt = 2'b01;
  localparam logic [1:0] CauseSw  = 2'b10;

  logic [SYNC_STAGES-1:0] rel_sync_q;
  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic [DebW-1:0]        deb_cnt_q;
  logic [1:0]             state_q, state_d;
  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [1:0]             cause_q, cause_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rst_async_q;
  logic                   rst_sync_q;
  logic                   done_q;

  logic por_rel, ext_s, ext_press, trig, rst_next;
  logic [1:0]       trig_cause;
  logic [CNT_W-1:0] cnt_inc;

  assign por_rel    = rel_sync_q[SYNC_STAGES-1];
  assign ext_s      = ext_sync_q[SYNC_STAGES-1];
  assign ext_press  = (deb_cnt_q == DebMax);
  assign trig       = por_rel & (ext_press | bus.sw_rst_i);
  // Pushbutton takes priority when both sources fire together
  assign trig_cause = ext_press ? CauseExt : CauseSw;
  assign cnt_inc    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  // Release chain shifts in 1 after reset rises; button chain idles high (not pressed)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rel_sync_q <= '0;
      ext_sync_q <= '1;
    end else begin
      rel_sync_q <= {rel_sync_q[SYNC_STAGES-2:0], 1'b1};
      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], bus.ext_rst_n};
    end
  end

  // Debounce: count consecutive low samples, saturate, any high sample clears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt_q <= '0;
    end else if (ext_s) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q != DebMax) begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end
  end

  // Next-state, hold countdown, cause and event-count decode
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    case (state_q)
      StAssert: begin
        // A held button keeps us here until it is released and the debouncer clears
        if (por_rel && !ext_press && !bus.sw_rst_i) begin
          state_d    = StHold;
          hold_cnt_d = HoldLoad;
        end
      end
      StHold: begin
        if (trig) begin
          state_d = StAssert;
          cause_d = trig_cause;
        end else if (hold_cnt_q == '0) begin
          state_d = StRelease;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      StRelease: begin
        if (trig) begin
          state_d = StAssert;
          cause_d = trig_cause;
          cnt_d   = cnt_inc;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (trig) begin
          state_d = StAssert;
          cause_d = trig_cause;
          cnt_d   = cnt_inc;
        end
      end
      default: state_d = StAssert;
    endcase
  end

  assign rst_next = (state_d == StAssert) || (state_d == StHold);

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StAssert;
      hold_cnt_q  <= '0;
      cause_q     <= CausePor;
      cnt_q       <= '0;
      rst_async_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      rst_async_q <= rst_next;
      done_q      <= (state_d == StRelease);
    end
  end

  // Purely synchronous reset copy; while reset is low state stays ASSERT so it loads 1
  always_ff @(posedge clk) begin
    rst_sync_q <= rst_next;
  end

  assign bus.rst_async_o = rst_async_q;
  assign bus.rst_sync_o  = rst_sync_q;
  assign bus.rst_done_o  = done_q;
  assign bus.busy_o      = (state_q != StRun);
  assign bus.cause_o     = cause_q;
  assign bus.rst_cnt_o   = cnt_q;

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer that sits directly upstream of the DFF bank (no-reset / sync-reset / async-reset flops).
- Produces the active-high reset that bank consumes, from three sources: power-on `reset`, a bouncy external pushbutton, and a software request.
- Guarantees async assertion with synchronous deassertion, and a minimum hold time.
- Reports completion, cause and event count.

Parameters:
- SYNC_STAGES, 2: depth of reset-release and ext_rst_n synchronizer chains (>=2)
- HOLD_CYCLES, 8: cycles reset stays asserted after a trigger clears (>=1)
- DEB_CYCLES, 4: consecutive low samples of synced ext_rst_n required to register a press (>=1)
- CNT_W, 8: width of reset event counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  power-on reset, asynchronous, active-low
- ext_rst_n  in  1  raw asynchronous pushbutton, active-low, may bounce
- sw_rst_i  in  1  synchronous software reset request, sampled each edge
- rst_async_o  out  1  active-high downstream reset; asserts asynchronously, deasserts on clk edge
- rst_sync_o  out  1  active-high downstream reset; changes only on clk edge
- rst_done_o  out  1  one-cycle pulse on reset release
- busy_o  out  1  high whenever state != RUN
- cause_o  out  2  last reset cause: 00 POR, 01 ext, 10 sw
- rst_cnt_o  out  CNT_W  ext/sw reset sequences started; saturating

Behaviour:
- **States:** ASSERT, HOLD, RELEASE, RUN; hold_cnt is ceil(log2(HOLD_CYCLES)) bits wide.
- **reset low, immediate (async):**
  - State, outputs and internal flops: state=ASSERT, rst_async_o=1, rst_done_o=0, busy_o=1, cause_o=00, rst_cnt_o=0, hold_cnt=0, deb_cnt=0.
  - Synchronizers: release chain cleared to 0; ext chain set to 1.
- **rst_sync_o while reset is low:** flop has no async reset. It loads 1 on every edge while reset is low or state is ASSERT/HOLD. Before the first edge it is unspecified.
- **Release synchronizer:** after reset rises, 1 shifts through SYNC_STAGES flops; por_rel = last stage.
- **Ext path:**
  - ext_rst_n is synced through SYNC_STAGES flops to ext_s.
  - deb_cnt increments while ext_s=0, saturating at DEB_CYCLES; any ext_s=1 clears it.
  - ext_press = (deb_cnt==DEB_CYCLES).
- **Trigger:** trig = ext_press | sw_rst_i, valid only when por_rel=1. If both are active, ext wins: cause=01 and a single count increment.
- **Transitions:**
  - ASSERT: por_rel=1 && !ext_press && !sw_rst_i -> HOLD, load hold_cnt=HOLD_CYCLES-1. Otherwise stay (an ext cause waits for button release/debounce clear).
  - HOLD: trig -> ASSERT, update cause, no count. Else hold_cnt==0 -> RELEASE. Else decrement.
  - RELEASE: lasts exactly one cycle. trig -> ASSERT (count+1, cause updated); else -> RUN.
  - RUN: trig -> ASSERT, cause updated, rst_cnt_o+1 (saturate at 2^CNT_W-1).
- **Output timing:**
  - rst_async_o and rst_sync_o are registered from next-state decode, so both equal 1 iff state is in {ASSERT, HOLD}. They change on the same edge as the state, glitch-free.
  - rst_done_o is registered =1 iff state==RELEASE.
  - busy_o = (state != RUN), so it stays high during RELEASE.
- **POR latency:** counting edge 1 as the first rising edge after reset rises:
  - por_rel high after edge SYNC_STAGES.
  - ASSERT->HOLD at edge SYNC_STAGES+1.
  - Outputs deassert at edge SYNC_STAGES+1+HOLD_CYCLES (default: edge 11).
  - rst_done_o high for the following cycle; RUN one edge later.
- **SW latency:** sw_rst_i high at edge E in RUN:
  - Outputs assert after E.
  - HOLD after E+1.
  - Deassert at E+1+HOLD_CYCLES (default E+9).
- **Ext latency:** a press needs SYNC_STAGES+DEB_CYCLES stable low edges. A bounce shorter than DEB_CYCLES is ignored entirely.
- **Reset mid-operation:** reset low in any state immediately returns to the POR values above. Cause and count are lost.

Test Plan:
- POR: reset low 20ns, release between edges, defaults -> rst_async_o=1 from reset fall; both resets deassert at 11th edge after release; rst_done_o one cycle; busy_o low next edge; cause_o=00, rst_cnt_o=0.
- SW request: in RUN, sw_rst_i high one cycle at edge E -> both resets 1 after E, 0 at E+9, rst_done_o at E+9..E+10, cause_o=10, rst_cnt_o=1.
- Debounce: ext_rst_n low 3 cycles, high 1, low 2 -> no reset. Then low 10 cycles -> press after 2+4 edges; reset held until ext released plus 8-cycle HOLD; cause_o=01, rst_cnt_o+1.
- Retrigger: sw_rst_i during HOLD at hold_cnt=3 -> back to ASSERT, full 8-cycle HOLD restarts, rst_cnt_o unchanged, single rst_done_o.
- Simultaneous: ext_press and sw_rst_i in same RUN cycle -> cause_o=01, rst_cnt_o +1 only. Saturation: CNT_W=2, 5 sw requests -> rst_cnt_o=3.
- Async abort: reset low mid-HOLD, off-edge -> rst_async_o stays 1, busy_o=1, cause_o=00, rst_cnt_o=0 immediately; POR sequence then repeats.
